seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
- Sequential shift-add multiplier that replaces the combinational AND-array/ripple-adder multiplier with a parametrised iterative datapath.
- It takes two WIDTH-bit operands on a start pulse and produces a 2*WIDTH-bit product after a fixed latency.
- It supports unsigned and two's-complement signed operation, selected per operation.
- It sits between switch/register inputs and LED/display outputs, or serves as a shared arithmetic unit under a controller.

Parameters:
- WIDTH, 5, operand width in bits (>=2); product width is 2*WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when the block is ready (IDLE or DONE).
- signed_mode  input  1  0 = unsigned, 1 = two's-complement; sampled with start.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high while an operation is in progress (CALC, SIGN).
- done  output  1  one-cycle pulse; product is valid.
- product  output  2*WIDTH  result; held until the next accepted start.

Behaviour:
- Reset (synchronous, active-high, dominant over everything):
  - State goes to IDLE; busy=0, done=0, product=0.
  - Internal accumulator, counter and latched operands are cleared.
- States: IDLE, CALC, SIGN, DONE.
- Accept (IDLE or DONE with start=1 at the edge):
  - If signed_mode=1, latch ma=|a| and mb=|b|; otherwise latch raw a and b.
  - Magnitudes are WIDTH-bit unsigned. The most negative value maps to 2^(WIDTH-1) with no overflow (e.g. -16 -> 16 for WIDTH=5).
  - Latch neg = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]).
  - acc=0, count=0; go to CALC. product keeps its old value until SIGN.
- CALC: one iteration per cycle, exactly WIDTH cycles.
  - If mb[0]=1: acc_hi (WIDTH+1 bits) = acc_hi + ma.
  - Then shift {acc, mb} right by one bit; count increments.
  - After the iteration with count=WIDTH-1, go to SIGN.
  - No early termination: latency is data-independent.
- SIGN (1 cycle):
  - product = neg ? (~acc + 1) mod 2^(2*WIDTH) : acc.
  - Go to DONE.
  - If either operand is zero and neg=1, the negation of 0 yields 0.
- DONE (1 cycle):
  - done=1, busy=0.
  - start=1 here is accepted: back-to-back operation goes directly to CALC.
  - Otherwise go to IDLE.
- Latency: start sampled at edge t0; CALC runs on edges t0+1..t0+WIDTH; SIGN writes product at edge t0+WIDTH+1; done=1 during the cycle t0+WIDTH+1..t0+WIDTH+2. Total WIDTH+2 cycles start-to-done.
- busy: 1 from edge t0 through edge t0+WIDTH+1 (CALC and SIGN); 0 in IDLE and DONE.
- start while busy=1 is ignored: no queuing, no effect on the running operation. a, b and signed_mode may change freely after acceptance.
- Range: the unsigned product max (2^WIDTH-1)^2 and the signed product range both fit in 2*WIDTH bits without overflow.
- Reset mid-operation: the next edge with reset=1 aborts, goes to IDLE and clears product; no done pulse is issued for the aborted operation.
- Simultaneous reset and start: reset wins.

Test Plan:
- WIDTH=5, unsigned, a=31, b=31, start one cycle -> busy high 6 cycles, done pulse at start+7 edges, product=961 (10'h3C1), then IDLE.
- WIDTH=5, signed, a=-3 (5'h1D), b=7 -> product=-21 (10'h3EB). Also a=-16, b=-16 -> product=256 (10'h100); a=-16, b=0 -> product=0.
- WIDTH=5, start pulsed on every cycle while busy, with a/b changing -> only the first operation completes, exactly one done pulse, product = first operands' product.
- WIDTH=5, start held high in the DONE cycle with new operands 12*10 unsigned -> no IDLE gap, second done 7 cycles after the first, product=120 (10'h078).
- Assert reset during CALC (3 cycles after start) -> next edge busy=0, done=0, product=0, no done pulse follows. A new start afterwards completes normally.
- WIDTH=8, unsigned 255*255 -> product=65025 (16'hFE01) after 10 cycles. Signed -128*127 -> product=-16256 (16'hC080).

Source files
------------

// File: rtl/seq_multiplier_if.sv
// Operand/result bus of the sequential multiplier: request side drives
// operands and start, the multiplier returns status and the product.
interface seq_multiplier_if #(
  parameter int unsigned WIDTH = 5
);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, one partial product per cycle.
// Signed operands are multiplied as magnitudes and the sign is applied
// in a dedicated cycle, so the latency is fixed at WIDTH+2 cycles.
module seq_multiplier #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  seq_multiplier_if.slave  bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  ma_q, ma_d;
  logic [WIDTH-1:0]  mb_q, mb_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     count_q, count_d;
  logic              neg_q, neg_d;
  logic [PW-1:0]     product_q, product_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [WIDTH-1:0]  mag_a_c;
  logic [WIDTH-1:0]  mag_b_c;
  logic [WIDTH:0]    sum_c;

  // Operand magnitudes; the most negative value maps onto 2^(WIDTH-1) unsigned.
  always_comb begin
    mag_a_c = bus.a;
    mag_b_c = bus.b;
    if (bus.signed_mode && bus.a[WIDTH-1]) mag_a_c = WIDTH'(0) - bus.a;
    if (bus.signed_mode && bus.b[WIDTH-1]) mag_b_c = WIDTH'(0) - bus.b;
  end

  // Upper accumulator half plus the multiplicand when the current multiplier bit is set.
  always_comb begin
    sum_c = {1'b0, acc_q[PW-1:WIDTH]};
    if (mb_q[0]) sum_c = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, ma_q};
  end

  // Next-state and datapath update for every state.
  always_comb begin
    state_d   = state_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    acc_d     = acc_q;
    count_d   = count_q;
    neg_d     = neg_q;
    product_d = product_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          ma_d    = mag_a_c;
          mb_d    = mag_b_c;
          neg_d   = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          acc_d   = '0;
          count_d = '0;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d   = {sum_c, acc_q[WIDTH-1:1]};
        mb_d    = mb_q >> 1;
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) state_d = SIGN;
      end
      SIGN: begin
        product_d = neg_q ? (PW'(0) - acc_q) : acc_q;
        state_d   = DONE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CALC) || (state_d == SIGN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers; synchronous reset dominates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ma_q      <= '0;
      mb_q      <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ma_q      <= ma_d;
      mb_q      <= mb_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and random checks of seq_multiplier at WIDTH=5 and WIDTH=8,
// with a product scoreboard per instance.
module tb_seq_multiplier;

  logic clk;
  logic reset;

  seq_multiplier_if #(.WIDTH(5)) bus5 ();
  seq_multiplier_if #(.WIDTH(8)) bus8 ();

  seq_multiplier #(.WIDTH(5)) dut5 (.clk(clk), .reset(reset), .bus(bus5));
  seq_multiplier #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

  int compared   = 0;
  int mismatched = 0;
  int done_cnt5  = 0;
  int done_cnt8  = 0;

  logic [63:0] q5[$];
  logic [63:0] q8[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference product computed from integer arithmetic, truncated to 2*w bits.
  function automatic logic [63:0] model(input int unsigned w, input logic [31:0] a,
                                        input logic [31:0] b, input logic sm);
    longint sa, sb;
    logic [63:0] mask;
    sa = longint'({32'd0, a});
    sb = longint'({32'd0, b});
    if (sm && a[w-1]) sa = sa - (longint'(1) << w);
    if (sm && b[w-1]) sb = sb - (longint'(1) << w);
    mask = (64'd1 << (2 * w)) - 64'd1;
    return 64'(sa * sb) & mask;
  endfunction

  // Scoreboards: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus5.done === 1'b1) begin
      done_cnt5++;
      if (q5.size() == 0) check("unexpected_done5", 64'd1, 64'd0);
      else check("product5", 64'(bus5.product), q5.pop_front());
    end
    if (bus8.done === 1'b1) begin
      done_cnt8++;
      if (q8.size() == 0) check("unexpected_done8", 64'd1, 64'd0);
      else check("product8", 64'(bus8.product), q8.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full WIDTH=5 operation with cycle-exact busy/done checks.
  task automatic op5(input logic [4:0] a, input logic [4:0] b, input logic sm);
    bus5.a = a; bus5.b = b; bus5.signed_mode = sm; bus5.start = 1'b1;
    q5.push_back(model(5, 32'(a), 32'(b), sm));
    step();
    check("busy_t0", 64'(bus5.busy), 64'd1);
    check("done_t0", 64'(bus5.done), 64'd0);
    bus5.start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      check("busy_calc", 64'(bus5.busy), 64'd1);
    end
    step();
    check("busy_done", 64'(bus5.busy), 64'd0);
    check("done_pulse", 64'(bus5.done), 64'd1);
    step();
    check("done_end", 64'(bus5.done), 64'd0);
    check("busy_idle", 64'(bus5.busy), 64'd0);
  endtask

  // WIDTH=8 operation with a bounded wait for done and a latency check.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sm);
    int k;
    bus8.a = a; bus8.b = b; bus8.signed_mode = sm; bus8.start = 1'b1;
    q8.push_back(model(8, 32'(a), 32'(b), sm));
    step();
    bus8.start = 1'b0;
    k = 0;
    while (bus8.done !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    check("latency8", 64'(k), 64'd9);
    step();
  endtask

  initial begin
    int dc;
    reset = 1'b1;
    bus5.start = 1'b0; bus5.signed_mode = 1'b0; bus5.a = '0; bus5.b = '0;
    bus8.start = 1'b0; bus8.signed_mode = 1'b0; bus8.a = '0; bus8.b = '0;
    repeat (3) step();
    check("rst_busy", 64'(bus5.busy), 64'd0);
    check("rst_done", 64'(bus5.done), 64'd0);
    check("rst_product", 64'(bus5.product), 64'd0);
    check("rst_product8", 64'(bus8.product), 64'd0);
    reset = 1'b0;
    step();

    // Unsigned max and signed corner cases.
    op5(5'd31, 5'd31, 1'b0);
    check("p_31x31", 64'(bus5.product), 64'h3C1);
    op5(5'h1D, 5'd7, 1'b1);
    check("p_m3x7", 64'(bus5.product), 64'h3EB);
    op5(5'h10, 5'h10, 1'b1);
    check("p_m16xm16", 64'(bus5.product), 64'h100);
    op5(5'h10, 5'h00, 1'b1);
    check("p_m16x0", 64'(bus5.product), 64'h000);

    // start held high with changing operands while busy: only the first op runs.
    dc = done_cnt5;
    bus5.a = 5'd6; bus5.b = 5'd7; bus5.signed_mode = 1'b0; bus5.start = 1'b1;
    q5.push_back(64'd42);
    step();
    for (int i = 1; i <= 6; i++) begin
      bus5.a = 5'($urandom); bus5.b = 5'($urandom); bus5.signed_mode = 1'($urandom);
      step();
    end
    check("busy_ignore_done", 64'(bus5.done), 64'd1);
    bus5.start = 1'b0;
    repeat (3) step();
    check("busy_ignore_count", 64'(done_cnt5 - dc), 64'd1);
    check("busy_ignore_prod", 64'(bus5.product), 64'd42);

    // Back-to-back: new start accepted in the DONE cycle.
    bus5.a = 5'd5; bus5.b = 5'd3; bus5.signed_mode = 1'b0; bus5.start = 1'b1;
    q5.push_back(64'd15);
    step();
    bus5.start = 1'b0;
    repeat (5) step();
    step();
    check("b2b_done1", 64'(bus5.done), 64'd1);
    bus5.a = 5'd12; bus5.b = 5'd10; bus5.start = 1'b1;
    q5.push_back(64'd120);
    step();
    check("b2b_busy", 64'(bus5.busy), 64'd1);
    check("b2b_nodone", 64'(bus5.done), 64'd0);
    bus5.start = 1'b0;
    repeat (5) step();
    step();
    check("b2b_done2", 64'(bus5.done), 64'd1);
    check("b2b_prod", 64'(bus5.product), 64'h078);
    step();

    // Reset three cycles into CALC aborts without a done pulse.
    bus5.a = 5'd9; bus5.b = 5'd9; bus5.signed_mode = 1'b0; bus5.start = 1'b1;
    step();
    bus5.start = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    check("abort_busy", 64'(bus5.busy), 64'd0);
    check("abort_done", 64'(bus5.done), 64'd0);
    check("abort_prod", 64'(bus5.product), 64'd0);
    reset = 1'b0;
    dc = done_cnt5;
    repeat (10) step();
    check("abort_no_done", 64'(done_cnt5 - dc), 64'd0);
    op5(5'd11, 5'd13, 1'b0);

    // Reset and start together: reset wins.
    reset = 1'b1; bus5.start = 1'b1; bus5.a = 5'd3; bus5.b = 5'd3;
    step();
    check("rst_start_busy", 64'(bus5.busy), 64'd0);
    reset = 1'b0; bus5.start = 1'b0;
    dc = done_cnt5;
    repeat (10) step();
    check("rst_start_no_done", 64'(done_cnt5 - dc), 64'd0);

    // Random WIDTH=5 operations.
    for (int i = 0; i < 8; i++) op5(5'($urandom), 5'($urandom), 1'($urandom));

    // WIDTH=8 corners and random operations.
    op8(8'd255, 8'd255, 1'b0);
    check("p8_255x255", 64'(bus8.product), 64'hFE01);
    op8(8'h80, 8'd127, 1'b1);
    check("p8_m128x127", 64'(bus8.product), 64'hC080);
    for (int i = 0; i < 6; i++) op8(8'($urandom), 8'($urandom), 1'($urandom));

    repeat (3) step();
    check("q5_empty", 64'(q5.size()), 64'd0);
    check("q8_empty", 64'(q8.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
